// File: rtl/fetch_ctrl_if.sv
// Decode-side fetch queue handshake: head instruction, its address, valid/ready.
// master is the fetch sequencer, slave is the consumer.
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32
);
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC drives a combinational ROM, fetched words queue in a DEPTH-entry FIFO.
// Push on the edge where rom_addr = A, head visible next cycle; full queue stalls PC unless popped.
module fetch_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    fetch_ctrl_if.master           q,
    output logic                   halted,
    output logic [15:0]            fetch_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc, pc_nxt;
    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic                   push, pop;

    logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_pc    [DEPTH];

    assign rom_addr    = pc;
    assign q.out_valid = (count != '0);
    assign q.out_instr = mem_instr[head];
    assign q.out_pc    = mem_pc[head];
    assign pop         = q.out_valid & q.out_ready;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        if (redirect_valid) begin
            state_nxt = FETCH;
            pc_nxt    = redirect_pc;
        end else begin
            unique case (state)
                FETCH: begin
                    // The all-zero word marks end of trace and is never queued.
                    if (rom_data == '0) begin
                        state_nxt = DRAIN;
                    end else if ((count < CW'(DEPTH)) || pop) begin
                        push   = 1'b1;
                        pc_nxt = pc + ADDR_WIDTH'(4);
                    end
                end
                DRAIN: begin
                    if ((count == '0) || ((count == CW'(1)) && pop))
                        state_nxt = HALTED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= !redirect_valid && (state == HALTED);
            if (push)
                fetch_count <= fetch_count + 16'd1;
            // Redirect discards every queued wrong-path entry, including one popped this cycle.
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + PW'(1);
                if (pop)
                    head <= head + PW'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail] <= rom_data;
            mem_pc[tail]    <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a ROM array answers rom_addr combinationally.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_ctrl;
    logic        clk;
    logic        reset;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] rom [0:1023];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl_if #(.ADDR_WIDTH(12), .INSTR_WIDTH(32)) q_if ();

    fetch_ctrl #(.ADDR_WIDTH(12), .INSTR_WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .q              (q_if.master),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign rom_data = rom[rom_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [11:0] a);
        return 32'hC0DE_0000 | {22'd0, a[11:2]};
    endfunction

    // First n words hold nonzero instructions, the rest are end markers.
    task automatic fill_rom(input int n);
        for (int i = 0; i < 1024; i++)
            rom[i] = (i < n) ? word_at(12'(i * 4)) : 32'd0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'd0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int          popped;
        logic [11:0] exp_pc;
        int          budget;

        q_if.out_ready = 1'b1;
        fill_rom(12);
        do_reset();

        // Reset state, before the first active edge after release
        check("rst_out_valid", {31'd0, q_if.out_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
        check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);

        // 12-instruction trace, consumer always ready
        step();
        check("first_valid", {31'd0, q_if.out_valid}, 32'd1);
        check("first_pc", {20'd0, q_if.out_pc}, 32'd0);
        popped = 0;
        exp_pc = 12'd0;
        budget = 0;
        while (popped < 12 && budget < 30) begin
            if (q_if.out_valid) begin
                check("trace_pc", {20'd0, q_if.out_pc}, {20'd0, exp_pc});
                check("trace_instr", q_if.out_instr, word_at(exp_pc));
                exp_pc = exp_pc + 12'd4;
                popped++;
            end
            step();
            budget++;
        end
        check("trace_pops", popped, 32'd12);
        check("trace_empty", {31'd0, q_if.out_valid}, 32'd0);
        check("trace_fetch_count", {16'd0, fetch_count}, 32'd12);
        check("trace_pc_frozen", {20'd0, rom_addr}, 32'h030);
        check("trace_not_halted_yet", {31'd0, halted}, 32'd0);
        budget = 0;
        while (!halted && budget < 4) begin
            step();
            budget++;
        end
        check("trace_halted", {31'd0, halted}, 32'd1);
        check("trace_halt_pc", {20'd0, rom_addr}, 32'h030);
        check("trace_halt_valid", {31'd0, q_if.out_valid}, 32'd0);

        // Back-pressure: queue fills and the PC stalls
        q_if.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("full_pc", {20'd0, rom_addr}, 32'h010);
        check("full_fetch_count", {16'd0, fetch_count}, 32'd4);
        check("full_head", {20'd0, q_if.out_pc}, 32'h000);

        // Simultaneous push and pop while full
        q_if.out_ready = 1'b1;
        step();
        check("pp_head", {20'd0, q_if.out_pc}, 32'h004);
        check("pp_pc", {20'd0, rom_addr}, 32'h014);
        check("pp_fetch_count", {16'd0, fetch_count}, 32'd5);
        q_if.out_ready = 1'b0;
        step();
        step();
        step();
        check("pp_still_full_pc", {20'd0, rom_addr}, 32'h014);
        check("pp_still_full_head", {20'd0, q_if.out_pc}, 32'h004);

        // Streaming with no gaps
        q_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", {31'd0, q_if.out_valid}, 32'd1);
            check("stream_pc", {20'd0, q_if.out_pc}, 32'(12'h008 + 12'(4 * i)));
        end
        check("stream_rom_addr", {20'd0, rom_addr}, 32'h024);
        check("stream_fetch_count", {16'd0, fetch_count}, 32'd9);

        // Redirect with 3 queued entries
        q_if.out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        check("pre_redir_pc", {20'd0, rom_addr}, 32'h00C);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h020;
        step();
        redirect_valid = 1'b0;
        check("redir_flush", {31'd0, q_if.out_valid}, 32'd0);
        check("redir_rom_addr", {20'd0, rom_addr}, 32'h020);
        check("redir_fetch_count", {16'd0, fetch_count}, 32'd3);
        step();
        check("redir_valid", {31'd0, q_if.out_valid}, 32'd1);
        check("redir_head_pc", {20'd0, q_if.out_pc}, 32'h020);
        check("redir_head_instr", q_if.out_instr, word_at(12'h020));
        check("redir_fetch_count2", {16'd0, fetch_count}, 32'd4);

        // Run to HALTED, then redirect back to 0
        q_if.out_ready = 1'b1;
        budget = 0;
        while (!halted && budget < 12) begin
            step();
            budget++;
        end
        check("halt2_halted", {31'd0, halted}, 32'd1);
        check("halt2_fetch_count", {16'd0, fetch_count}, 32'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h000;
        step();
        redirect_valid = 1'b0;
        check("unhalt_halted", {31'd0, halted}, 32'd0);
        check("unhalt_rom_addr", {20'd0, rom_addr}, 32'h000);
        step();
        check("unhalt_valid", {31'd0, q_if.out_valid}, 32'd1);
        check("unhalt_head_pc", {20'd0, q_if.out_pc}, 32'h000);
        check("unhalt_fetch_count", {16'd0, fetch_count}, 32'd8);

        // PC wrap from 0xFFC
        rom[1023]      = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_rom_addr", {20'd0, rom_addr}, 32'hFFC);
        check("wrap_flush", {31'd0, q_if.out_valid}, 32'd0);
        step();
        check("wrap_head_pc", {20'd0, q_if.out_pc}, 32'hFFC);
        check("wrap_head_instr", q_if.out_instr, 32'hDEAD_BEEF);
        check("wrap_next_addr", {20'd0, rom_addr}, 32'h000);

        // Reset mid-stream overrides a concurrent redirect
        step();
        step();
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h040;
        step();
        check("midrst_valid", {31'd0, q_if.out_valid}, 32'd0);
        check("midrst_fetch_count", {16'd0, fetch_count}, 32'd0);
        check("midrst_rom_addr", {20'd0, rom_addr}, 32'd0);
        check("midrst_halted", {31'd0, halted}, 32'd0);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
